lsu_dmem_ctrl: RTL and testbench



---
 rtl/lsu_dmem_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_lsu_dmem_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit for word-organised DMEM: sub-word RMW stores, sign/zero-extended loads.
// Optional LSU_MISALIGN_SPLIT_EN splits word-crossing accesses over two DMEM cycles.
module lsu_dmem_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_st_data_o,
  output logic              dmem_st_en_o,
  input  logic [DATA_W-1:0] dmem_ld_data_i
);

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;
`else
  typedef enum logic [1:0] {IDLE, ACC0, RESP} state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d, uns_q, uns_d, err_q, err_d, st_en_q, st_en_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]        k;
  logic [3:0]        lane_base, lane_lo;
  logic [31:0]       mask_lo, wsh_lo, merged_lo;
  logic [31:0]       lo_src, ld_sh, ld_ext;
  logic [23:0]       hi_src;
  logic [55:0]       ld_pair;
  logic              cross_in, err_in;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic              cross_q, cross_d;
  logic [31:0]       buf0_q, buf0_d;
  logic [3:0]        lane_hi;
  logic [31:0]       mask_hi, wsh_hi, merged_hi;
`endif

  assign k = addr_q[1:0];

  // Byte-lane masks over {word1, word0}; the upper word only exists for split accesses.
  always_comb begin
    case (size_q)
      2'b00:   lane_base = 4'b0001;
      2'b01:   lane_base = 4'b0011;
      default: lane_base = 4'b1111;
    endcase
    lane_lo = lane_base << k;
    wsh_lo  = wdata_q << {k, 3'b000};
    mask_lo = '0;
    for (int unsigned i = 0; i < 4; i++) mask_lo[8*i +: 8] = {8{lane_lo[i]}};
    merged_lo = (dmem_ld_data_i & ~mask_lo) | (wsh_lo & mask_lo);
`ifdef LSU_MISALIGN_SPLIT_EN
    lane_hi = lane_base >> (3'd4 - {1'b0, k});
    wsh_hi  = wdata_q >> (6'd32 - {1'b0, k, 3'b000});
    mask_hi = '0;
    for (int unsigned i = 0; i < 4; i++) mask_hi[8*i +: 8] = {8{lane_hi[i]}};
    merged_hi = (dmem_ld_data_i & ~mask_hi) | (wsh_hi & mask_hi);
`endif
  end

  always_comb begin
    lo_src = dmem_ld_data_i;
    hi_src = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
    if (state_q == ACC1) begin
      lo_src = buf0_q;
      hi_src = dmem_ld_data_i[23:0];
    end
`endif
    ld_pair = {hi_src, lo_src};
    ld_sh   = ld_pair[{k, 3'b000} +: 32];
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'b0, ld_sh[7:0]}  : {{24{ld_sh[7]}}, ld_sh[7:0]};
      2'b01:   ld_ext = uns_q ? {16'b0, ld_sh[15:0]} : {{16{ld_sh[15]}}, ld_sh[15:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  assign cross_in = ((req_size_i == 2'b01) && (req_addr_i[1:0] == 2'b11)) ||
                    ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));

  always_comb begin
    err_in = (req_size_i == 2'b11) || (|req_addr_i[31:ADDR_W+2]);
`ifndef LSU_MISALIGN_SPLIT_EN
    err_in = err_in || cross_in;
`endif
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    size_d         = size_q;
    we_d           = we_q;
    uns_d          = uns_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    st_en_d        = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    cross_d        = cross_q;
    buf0_d         = buf0_q;
`endif
    req_ready_o    = 1'b0;
    rsp_valid_o    = 1'b0;
    dmem_addr_o    = '0;
    dmem_st_data_o = '0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d  = req_addr_i[ADDR_W+1:0];
          size_d  = req_size_i;
          we_d    = req_we_i;
          uns_d   = req_unsigned_i;
          wdata_d = req_wdata_i;
          rdata_d = '0;
          err_d   = err_in;
`ifdef LSU_MISALIGN_SPLIT_EN
          cross_d = cross_in;
`endif
          if (err_in) begin
            state_d = RESP;
          end else begin
            state_d = ACC0;
            // Write enable is registered so DMEM's clock gate never sees req_* glitches.
            st_en_d = req_we_i;
          end
        end
      end
      ACC0: begin
        dmem_addr_o    = addr_q[ADDR_W+1:2];
        dmem_st_data_o = we_q ? merged_lo : '0;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (cross_q) begin
          state_d = ACC1;
          st_en_d = we_q;
          buf0_d  = dmem_ld_data_i;
        end else begin
          state_d = RESP;
          rdata_d = we_q ? '0 : ld_ext;
        end
`else
        state_d = RESP;
        rdata_d = we_q ? '0 : ld_ext;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ACC1: begin
        dmem_addr_o    = addr_q[ADDR_W+1:2] + 1'b1;
        dmem_st_data_o = we_q ? merged_hi : '0;
        state_d        = RESP;
        rdata_d        = we_q ? '0 : ld_ext;
      end
`endif
      RESP: begin
        rsp_valid_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      st_en_q <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      cross_q <= 1'b0;
      buf0_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      st_en_q <= st_en_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      cross_q <= cross_d;
      buf0_q  <= buf0_d;
`endif
    end
  end

  assign dmem_st_en_o = st_en_q;
  assign rsp_rdata_o  = rdata_q;
  assign rsp_err_o    = err_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed self-checking bench for lsu_dmem_ctrl with a behavioural DMEM;
// crossing-access expectations follow LSU_MISALIGN_SPLIT_EN.
module tb_lsu_dmem_ctrl;
  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0, req_ready, req_we = 1'b0, req_uns = 1'b0;
  logic [31:0]       req_addr = '0, req_wdata = '0;
  logic [1:0]        req_size = '0;
  logic              rsp_valid, rsp_err, st_en;
  logic [31:0]       rsp_rdata, st_data, ld_data;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  int                checks = 0;
  int                errors = 0;

  lsu_dmem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_unsigned_i(req_uns),
    .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .dmem_addr_o(dmem_addr), .dmem_st_data_o(st_data),
    .dmem_st_en_o(st_en), .dmem_ld_data_i(ld_data)
  );

  always #5 clk = ~clk;

  assign ld_data = mem[dmem_addr];
  always @(posedge clk) if (st_en) mem[dmem_addr] <= st_data;

  // Issue one request and wait (bounded) for its response; lat counts edges from the accepting edge.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd, output logic [31:0] rd,
                        output logic err, output int lat, output int wr, output logic one_pulse);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_uns = uns; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    lat = 1; wr = 0;
    while (!rsp_valid && lat < 10) begin
      if (st_en) wr++;
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata; err = rsp_err;
    @(posedge clk); #1;
    one_pulse = !rsp_valid;
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 ||
        st_en !== 1'b0 || dmem_addr !== '0 || st_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b err=%b rdata=%h st_en=%b addr=%h st_data=%h (want 1 0 0 0 0 0 0)",
               req_ready, rsp_valid, rsp_err, rsp_rdata, st_en, dmem_addr, st_data);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic err, p; int lat, wr;
    do_req(1'b1, 32'h010, 2'b10, 1'b0, 32'hDEADBEEF, rd, err, lat, wr, p);
    checks++;
    if (mem[4] !== 32'hDEADBEEF || err !== 1'b0 || lat !== 2 || wr !== 1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL word_store: mem=%h err=%b lat=%0d wr=%0d rd=%h (want DEADBEEF 0 2 1 0)", mem[4], err, lat, wr, rd);
    end
    do_req(1'b0, 32'h010, 2'b10, 1'b0, 32'h0, rd, err, lat, wr, p);
    checks++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0 || lat !== 2 || wr !== 0) begin
      errors++;
      $display("FAIL word_load: rd=%h err=%b lat=%0d wr=%0d (want DEADBEEF 0 2 0)", rd, err, lat, wr);
    end
    checks++;
    if (p !== 1'b1) begin
      errors++;
      $display("FAIL rsp_single_pulse: valid_after=%b (want 0)", !p);
    end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic err, p; int lat, wr;
    do_req(1'b1, 32'h012, 2'b00, 1'b0, 32'h00000055, rd, err, lat, wr, p);
    checks++;
    if (mem[4] !== 32'hDE55BEEF || err !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL byte_store: mem=%h err=%b lat=%0d (want DE55BEEF 0 2)", mem[4], err, lat);
    end
    do_req(1'b0, 32'h013, 2'b00, 1'b0, 32'h0, rd, err, lat, wr, p);
    checks++;
    if (rd !== 32'hFFFFFFDE || err !== 1'b0) begin
      errors++;
      $display("FAIL byte_load_signed: rd=%h err=%b (want FFFFFFDE 0)", rd, err);
    end
    do_req(1'b0, 32'h013, 2'b00, 1'b1, 32'h0, rd, err, lat, wr, p);
    checks++;
    if (rd !== 32'h000000DE || err !== 1'b0) begin
      errors++;
      $display("FAIL byte_load_unsigned: rd=%h err=%b (want 000000DE 0)", rd, err);
    end
    do_req(1'b0, 32'h012, 2'b01, 1'b1, 32'h0, rd, err, lat, wr, p);
    checks++;
    if (rd !== 32'h0000DE55 || err !== 1'b0) begin
      errors++;
      $display("FAIL half_load_unsigned: rd=%h err=%b (want 0000DE55 0)", rd, err);
    end
    do_req(1'b0, 32'h010, 2'b01, 1'b0, 32'h0, rd, err, lat, wr, p);
    checks++;
    if (rd !== 32'hFFFFBEEF || err !== 1'b0) begin
      errors++;
      $display("FAIL half_load_signed: rd=%h err=%b (want FFFFBEEF 0)", rd, err);
    end
  endtask

  task automatic test_crossing();
    logic [31:0] rd; logic err, p; int lat, wr;
    mem[8] <= 32'h44332211; mem[9] <= 32'h88776655;
    mem[10'h3FF] <= 32'h11223344; mem[0] <= 32'h55667788;
    @(posedge clk); #1;
    do_req(1'b0, 32'h023, 2'b01, 1'b0, 32'h0, rd, err, lat, wr, p);
`ifdef LSU_MISALIGN_SPLIT_EN
    checks++;
    if (rd !== 32'h00005544 || err !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL cross_half_load: rd=%h err=%b lat=%0d (want 00005544 0 3)", rd, err, lat);
    end
    do_req(1'b0, 32'h021, 2'b10, 1'b0, 32'h0, rd, err, lat, wr, p);
    checks++;
    if (rd !== 32'h55443322 || err !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL cross_word_load: rd=%h err=%b lat=%0d (want 55443322 0 3)", rd, err, lat);
    end
    do_req(1'b1, 32'h023, 2'b01, 1'b0, 32'h0000BEEF, rd, err, lat, wr, p);
    checks++;
    if (mem[8] !== 32'hEF332211 || mem[9] !== 32'h887766BE || wr !== 2 || lat !== 3) begin
      errors++;
      $display("FAIL cross_half_store: w8=%h w9=%h wr=%0d lat=%0d (want EF332211 887766BE 2 3)", mem[8], mem[9], wr, lat);
    end
    do_req(1'b1, 32'h0FFE, 2'b10, 1'b0, 32'hAABBCCDD, rd, err, lat, wr, p);
    checks++;
    if (mem[10'h3FF] !== 32'hCCDD3344 || mem[0] !== 32'h5566AABB || err !== 1'b0 || wr !== 2) begin
      errors++;
      $display("FAIL wrap_store: w3ff=%h w0=%h err=%b wr=%0d (want CCDD3344 5566AABB 0 2)", mem[10'h3FF], mem[0], err, wr);
    end
`else
    checks++;
    if (rd !== 32'h0 || err !== 1'b1 || lat !== 1 || wr !== 0) begin
      errors++;
      $display("FAIL cross_half_load_err: rd=%h err=%b lat=%0d wr=%0d (want 0 1 1 0)", rd, err, lat, wr);
    end
    do_req(1'b1, 32'h0FFE, 2'b10, 1'b0, 32'hAABBCCDD, rd, err, lat, wr, p);
    checks++;
    if (mem[10'h3FF] !== 32'h11223344 || mem[0] !== 32'h55667788 || err !== 1'b1 || wr !== 0) begin
      errors++;
      $display("FAIL cross_store_err: w3ff=%h w0=%h err=%b wr=%0d (want 11223344 55667788 1 0)", mem[10'h3FF], mem[0], err, wr);
    end
`endif
  endtask

  task automatic test_errors();
    logic [31:0] rd, w0, w4; logic err, p; int lat, wr;
    w0 = mem[0]; w4 = mem[4];
    do_req(1'b1, 32'h1000, 2'b10, 1'b0, 32'h12345678, rd, err, lat, wr, p);
    checks++;
    if (err !== 1'b1 || rd !== 32'h0 || lat !== 1 || wr !== 0 || mem[0] !== w0) begin
      errors++;
      $display("FAIL out_of_range: err=%b rd=%h lat=%0d wr=%0d w0=%h (want 1 0 1 0 %h)", err, rd, lat, wr, mem[0], w0);
    end
    do_req(1'b1, 32'h010, 2'b11, 1'b0, 32'h12345678, rd, err, lat, wr, p);
    checks++;
    if (err !== 1'b1 || rd !== 32'h0 || lat !== 1 || wr !== 0 || mem[4] !== w4) begin
      errors++;
      $display("FAIL size_reserved: err=%b rd=%h lat=%0d wr=%0d w4=%h (want 1 0 1 0 %h)", err, rd, lat, wr, mem[4], w4);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err, p; int lat, wr;
    do_req(1'b1, 32'h040, 2'b10, 1'b0, 32'hCAFEF00D, rd, err, lat, wr, p);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_resp: ready=%b (want 1)", req_ready);
    end
    do_req(1'b0, 32'h042, 2'b01, 1'b0, 32'h0, rd, err, lat, wr, p);
    checks++;
    if (rd !== 32'hFFFFCAFE || err !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL back_to_back_load: rd=%h err=%b lat=%0d (want FFFFCAFE 0 2)", rd, err, lat);
    end
  endtask

  task automatic test_midreset();
    logic seen_valid;
    seen_valid = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h030; req_size = 2'b10; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    checks++;
    if (st_en !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_in_acc0: st_en=%b ready=%b (want 1 0)", st_en, req_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (st_en !== 1'b0) begin
      errors++;
      $display("FAIL midreset_st_en_drop: st_en=%b (want 0)", st_en);
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (rsp_valid) seen_valid = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0 || req_ready !== 1'b1 || mem[12] !== 32'h0) begin
      errors++;
      $display("FAIL midreset_after: rsp_seen=%b ready=%b w12=%h (want 0 1 00000000)", seen_valid, req_ready, mem[12]);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_word();
    test_subword();
    test_crossing();
    test_errors();
    test_back_to_back();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
